// File: rtl/axi_resp_pkg.sv
// Shared types and constants for the AXI read responder.
// The request struct is sized by the AXI_* constants below; the top-level
// parameter defaults are tied to them, so change both together.
package axi_resp_pkg;

   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_LEN_BITS  = 8;
   localparam int AXI_ID_BITS   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } resp_state_e;

   typedef struct packed {
      logic [AXI_ADDR_BITS-1:0] addr;
      logic [AXI_LEN_BITS-1:0]  len;
      logic [AXI_ID_BITS-1:0]   id;
   } ar_req_t;

   // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AR/R read-channel bundle between a read master and the responder.
interface axi_read_responder_if #(
   parameter int ADDR_BITS            = 32,
   parameter int TID_WIDTH            = 4,
   parameter int BURST_LEN_WIDTH      = 8,
   parameter int LOG_BLOCK_DATA_BYTES = 3
);
   localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;

   logic                       s_ar_valid;
   logic                       s_ar_ready;
   logic [BURST_LEN_WIDTH-1:0] s_ar_len;
   logic [ADDR_BITS-1:0]       s_ar_addr;
   logic [TID_WIDTH-1:0]       s_ar_id;
   logic                       s_r_valid;
   logic                       s_r_ready;
   logic                       s_r_last;
   logic [DATA_BITS-1:0]       s_r_data;
   logic [TID_WIDTH-1:0]       s_r_id;

   modport slave (
      input  s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
      output s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id
   );

   modport master (
      output s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
      input  s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id
   );

endinterface

// File: rtl/axi_read_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is visible combinationally.
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int LOG_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head,
   output logic                 full,
   output logic                 empty,
   output logic [LOG_DEPTH:0]   count
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // storage array; no reset needed, validity tracked by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // count tops out at DEPTH, the only value with the MSB set
   assign full  = count[LOG_DEPTH];
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/axi_read_responder.sv
// AXI read slave: queues AR requests in order and returns INCR bursts whose
// data is the beat address replicated across the data bus.
// Optional macro AXI_RESP_STALL_EN inserts LFSR-driven bubbles on R.
//
// state | meaning
// IDLE  | no active burst; launches the FIFO head when one is queued
// WAIT  | latency countdown before the first beat
// BURST | presenting beats on R until the last one is accepted
module axi_read_responder
   import axi_resp_pkg::*;
#(
   parameter int ADDR_BITS            = AXI_ADDR_BITS,
   parameter int TID_WIDTH            = AXI_ID_BITS,
   parameter int BURST_LEN_WIDTH      = AXI_LEN_BITS,
   parameter int LOG_BLOCK_DATA_BYTES = 3,
   parameter int LOG_OUTSTANDING      = 2,
   parameter int LAT_WIDTH            = 8
) (
   input  logic                     clk,
   input  logic                     resetN,
   axi_read_responder_if.slave      bus,
   input  logic [LAT_WIDTH-1:0]     respLatency,
   output logic [LOG_OUTSTANDING:0] outstandingCnt
);

   localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;
   localparam logic [ADDR_BITS-1:0] BEAT_BYTES = ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES;

   resp_state_e                state;
   resp_state_e                state_next;
   ar_req_t                    push_req;
   ar_req_t                    head_req;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [LOG_OUTSTANDING:0]   fifo_count;
   logic                       ready_en;
   logic                       ar_fire;
   logic                       launch;
   logic                       r_valid;
   logic                       r_last;
   logic                       beat_fire;
   logic [LAT_WIDTH-1:0]       lat_cnt;
   logic [BURST_LEN_WIDTH-1:0] beat_cnt;
   logic [BURST_LEN_WIDTH-1:0] act_len;
   logic [TID_WIDTH-1:0]       act_id;
   logic [ADDR_BITS-1:0]       beat_addr;
   logic [63:0]                addr64;

   // pack the incoming request for the queue
   always_comb begin
      push_req      = '0;
      push_req.addr = AXI_ADDR_BITS'(bus.s_ar_addr);
      push_req.len  = AXI_LEN_BITS'(bus.s_ar_len);
      push_req.id   = AXI_ID_BITS'(bus.s_ar_id);
   end

   sync_fifo #(
      .WIDTH     ($bits(ar_req_t)),
      .LOG_DEPTH (LOG_OUTSTANDING)
   ) u_ar_fifo (
      .clk       (clk),
      .resetN    (resetN),
      .push      (ar_fire),
      .push_data (push_req),
      .pop       (launch),
      .head      (head_req),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // holds AR ready low while in reset; ready depends on registers only
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) ready_en <= 1'b0;
      else         ready_en <= 1'b1;
   end

   assign bus.s_ar_ready = ready_en & ~fifo_full;
   assign ar_fire        = bus.s_ar_valid & bus.s_ar_ready;

`ifdef AXI_RESP_STALL_EN
   logic [15:0] lfsr;
   logic        held;

   // free-running bubble generator
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) lfsr <= LFSR_SEED;
      else         lfsr <= lfsr_step(lfsr);
   end

   // a presented beat that was not taken must stay valid
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) held <= 1'b0;
      else         held <= r_valid & ~bus.s_r_ready;
   end

   assign r_valid = (state == BURST) & (held | ~lfsr[0]);
`else
   assign r_valid = (state == BURST);
`endif

   assign r_last    = (state == BURST) & (beat_cnt == act_len);
   assign beat_fire = r_valid & bus.s_r_ready;

   // state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_next;
   end

   // next state; a new burst may launch straight out of the last beat
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      unique case (state)
         IDLE:  launch = ~fifo_empty;
         WAIT:  if (lat_cnt == LAT_WIDTH'(1)) state_next = BURST;
         BURST: begin
            if (beat_fire && r_last) begin
               if (fifo_empty) state_next = IDLE;
               else            launch     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (launch) state_next = (respLatency == '0) ? BURST : WAIT;
   end

   // active burst registers and latency/beat counters
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         beat_addr <= '0;
         act_len   <= '0;
         act_id    <= '0;
         beat_cnt  <= '0;
         lat_cnt   <= '0;
      end else if (launch) begin
         beat_addr <= ADDR_BITS'(head_req.addr);
         act_len   <= BURST_LEN_WIDTH'(head_req.len);
         act_id    <= TID_WIDTH'(head_req.id);
         beat_cnt  <= '0;
         lat_cnt   <= respLatency;
      end else begin
         if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
         if (beat_fire && !r_last) begin
            beat_cnt  <= beat_cnt + 1'b1;
            beat_addr <= beat_addr + BEAT_BYTES;
         end
      end
   end

   // beat address zero-extended to 64 bits, then replicated across the bus
   always_comb begin
      addr64                = '0;
      addr64[ADDR_BITS-1:0] = beat_addr;
   end

   for (genvar g = 0; g < DATA_BITS; g++) begin : g_data
      assign bus.s_r_data[g] = addr64[g % 64];
   end

   assign bus.s_r_valid  = r_valid;
   assign bus.s_r_last   = r_last;
   assign bus.s_r_id     = act_id;
   assign outstandingCnt = fifo_count + {{LOG_OUTSTANDING{1'b0}}, (state != IDLE)};

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: table of single bursts plus
// backpressure, full-queue, and reset-during-burst sequences.
module tb_axi_read_responder;

   localparam int ADDR_BITS            = 32;
   localparam int TID_WIDTH            = 4;
   localparam int BURST_LEN_WIDTH      = 8;
   localparam int LOG_BLOCK_DATA_BYTES = 3;
   localparam int LOG_OUTSTANDING      = 2;
   localparam int LAT_WIDTH            = 8;

   typedef struct packed {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [3:0]       id;
      logic [7:0]       lat;
      logic [3:0][63:0] exp_data;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     resetN = 1'b0;
   logic [LAT_WIDTH-1:0]     respLatency;
   logic [LOG_OUTSTANDING:0] outstandingCnt;
   int                       cyc = 0;
   int                       n_tests = 0;
   int                       n_fail = 0;
   vec_t                     vecs[5];

   axi_read_responder_if #(
      .ADDR_BITS            (ADDR_BITS),
      .TID_WIDTH            (TID_WIDTH),
      .BURST_LEN_WIDTH      (BURST_LEN_WIDTH),
      .LOG_BLOCK_DATA_BYTES (LOG_BLOCK_DATA_BYTES)
   ) bus ();

   axi_read_responder #(
      .ADDR_BITS            (ADDR_BITS),
      .TID_WIDTH            (TID_WIDTH),
      .BURST_LEN_WIDTH      (BURST_LEN_WIDTH),
      .LOG_BLOCK_DATA_BYTES (LOG_BLOCK_DATA_BYTES),
      .LOG_OUTSTANDING      (LOG_OUTSTANDING),
      .LAT_WIDTH            (LAT_WIDTH)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .bus            (bus),
      .respLatency    (respLatency),
      .outstandingCnt (outstandingCnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i,
                          output int hs);
      hs = -1;
      @(negedge clk);
      bus.s_ar_addr  = a;
      bus.s_ar_len   = l;
      bus.s_ar_id    = i;
      bus.s_ar_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         if (bus.s_ar_ready) begin
            hs = cyc;
            break;
         end
         @(negedge clk);
      end
      if (hs < 0) check("ar_accept_timeout", bus.s_ar_ready, 1);
      @(posedge clk);
      #1 bus.s_ar_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  hs;
      int  beat;
      bit  done;
      bus.s_r_ready = 1'b1;
      respLatency   = v.lat;
      send_ar(v.addr, v.len, v.id, hs);
      beat = 0;
      done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (bus.s_r_valid) begin
            if (beat == 0) begin
`ifndef AXI_RESP_STALL_EN
               check($sformatf("v%0d_first_valid_delay", idx), cyc - hs, 2 + int'(v.lat));
`endif
               check($sformatf("v%0d_outstanding_busy", idx), outstandingCnt, 1);
            end
            check($sformatf("v%0d_data_b%0d", idx, beat), bus.s_r_data, v.exp_data[beat]);
            check($sformatf("v%0d_id_b%0d", idx, beat), bus.s_r_id, v.id);
            check($sformatf("v%0d_last_b%0d", idx, beat), bus.s_r_last, (beat == int'(v.len)));
            beat++;
            if (beat > int'(v.len)) done = 1;
         end
      end
      if (!done) check($sformatf("v%0d_beat_timeout", idx), beat, int'(v.len) + 1);
      @(negedge clk);
      check($sformatf("v%0d_outstanding_done", idx), outstandingCnt, 0);
      check($sformatf("v%0d_valid_done", idx), bus.s_r_valid, 0);
   endtask

   initial begin
      int hs;
      int exp_id;
      int beat;
      int acc_beats;
      int hs6_beats;
      bit ar_drop;

      bus.s_ar_valid = 1'b0;
      bus.s_ar_addr  = '0;
      bus.s_ar_len   = '0;
      bus.s_ar_id    = '0;
      bus.s_r_ready  = 1'b0;
      respLatency    = '0;

      vecs[0] = '{addr: 32'h0000_1000, len: 8'd3, id: 4'd5, lat: 8'd0,
                  exp_data: {64'h1018, 64'h1010, 64'h1008, 64'h1000}};
      vecs[1] = '{addr: 32'h0000_0040, len: 8'd0, id: 4'd2, lat: 8'd10,
                  exp_data: {64'h0, 64'h0, 64'h0, 64'h40}};
      vecs[2] = '{addr: 32'hFFFF_FFF8, len: 8'd1, id: 4'd7, lat: 8'd3,
                  exp_data: {64'h0, 64'h0, 64'h0, 64'h0000_0000_FFFF_FFF8}};
      vecs[3] = '{addr: 32'h0000_1234, len: 8'd2, id: 4'hF, lat: 8'd1,
                  exp_data: {64'h0, 64'h1244, 64'h123C, 64'h1234}};
      vecs[4] = '{addr: 32'h0000_6000, len: 8'd0, id: 4'd4, lat: 8'd2,
                  exp_data: {64'h0, 64'h0, 64'h0, 64'h6000}};

      // reset values
      #12;
      check("rst_ar_ready", bus.s_ar_ready, 0);
      check("rst_r_valid", bus.s_r_valid, 0);
      check("rst_r_last", bus.s_r_last, 0);
      check("rst_r_data", bus.s_r_data, 0);
      check("rst_r_id", bus.s_r_id, 0);
      check("rst_outstanding", outstandingCnt, 0);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check("post_rst_ar_ready", bus.s_ar_ready, 1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // backpressure: first beat held for several cycles
      bus.s_r_ready = 1'b0;
      respLatency   = '0;
      send_ar(32'h2000, 8'd1, 4'd3, hs);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus.s_r_valid) break;
      end
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold_valid_%0d", k), bus.s_r_valid, 1);
         check($sformatf("bp_hold_data_%0d", k), bus.s_r_data, 64'h2000);
         check($sformatf("bp_hold_last_%0d", k), bus.s_r_last, 0);
         @(negedge clk);
      end
      check("bp_before_ready_data", bus.s_r_data, 64'h2000);
      bus.s_r_ready = 1'b1;
      @(negedge clk);
      check("bp_beat2_valid", bus.s_r_valid, 1);
      check("bp_beat2_data", bus.s_r_data, 64'h2008);
      check("bp_beat2_last", bus.s_r_last, 1);
      @(negedge clk);
      check("bp_done_valid", bus.s_r_valid, 0);
      check("bp_done_outstanding", outstandingCnt, 0);

      // full queue: one active burst plus four queued, sixth request waits
      bus.s_r_ready = 1'b0;
      respLatency   = '0;
      for (int i = 1; i <= 5; i++) send_ar(32'h3000 + 32'(i) * 32'h100, 8'd1, 4'(i), hs);
      @(negedge clk);
      check("full_ar_ready", bus.s_ar_ready, 0);
      check("full_outstanding", outstandingCnt, 5);
      bus.s_ar_addr  = 32'h3600;
      bus.s_ar_len   = 8'd1;
      bus.s_ar_id    = 4'd6;
      bus.s_ar_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("full_ar_blocked", bus.s_ar_ready, 0);
      bus.s_r_ready = 1'b1;
      exp_id    = 1;
      beat      = 0;
      acc_beats = 0;
      hs6_beats = -1;
      ar_drop   = 0;
      for (int t = 0; t < 300 && exp_id <= 6; t++) begin
         if (bus.s_ar_valid && bus.s_ar_ready) begin
            hs6_beats = acc_beats;
            ar_drop   = 1;
         end
         if (bus.s_r_valid) begin
            check($sformatf("fifo_id_%0d_b%0d", exp_id, beat), bus.s_r_id, exp_id);
            check($sformatf("fifo_data_%0d_b%0d", exp_id, beat), bus.s_r_data,
                  64'h3000 + 64'(exp_id) * 64'h100 + 64'(beat) * 64'h8);
            check($sformatf("fifo_last_%0d_b%0d", exp_id, beat), bus.s_r_last, (beat == 1));
            acc_beats++;
            beat++;
            if (beat == 2) begin
               beat = 0;
               exp_id++;
            end
         end
         if (ar_drop) begin
            @(posedge clk);
            #1 bus.s_ar_valid = 1'b0;
            ar_drop = 0;
         end
         @(negedge clk);
      end
      check("fifo_all_bursts", exp_id, 7);
      check("fifo_6th_after_burst1", hs6_beats, 2);
      check("fifo_outstanding_done", outstandingCnt, 0);

      // reset asserted while beat 2 of an 8-beat burst is on the bus
      bus.s_r_ready = 1'b1;
      respLatency   = '0;
      send_ar(32'h5000, 8'd7, 4'd9, hs);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.s_r_valid && bus.s_r_data == 64'h5008) break;
      end
      check("rstmid_beat2_seen", bus.s_r_data, 64'h5008);
      resetN = 1'b0;
      #1;
      check("rstmid_r_valid", bus.s_r_valid, 0);
      check("rstmid_outstanding", outstandingCnt, 0);
      check("rstmid_ar_ready", bus.s_ar_ready, 0);
      check("rstmid_r_last", bus.s_r_last, 0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      run_vec(vecs[4], 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
